// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port sharing arbiter:
// datapath widths, port id type, issue-stage record and ALU opcodes.
package alu_pkg;

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 6;

  // Requester id (two requesters share the ALU)
  typedef logic port_id_t;

  // Contents of the registered issue stage in front of the ALU
  typedef struct packed {
    logic            valid;
    port_id_t        id;
    logic [OPW-1:0]  op;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
  } issue_t;

  localparam logic [OPW-1:0] ALU_ADD  = OPW'(0);
  localparam logic [OPW-1:0] ALU_SUB  = OPW'(1);
  localparam logic [OPW-1:0] ALU_AND  = OPW'(2);
  localparam logic [OPW-1:0] ALU_OR   = OPW'(3);
  localparam logic [OPW-1:0] ALU_XOR  = OPW'(4);
  localparam logic [OPW-1:0] ALU_SLL  = OPW'(5);
  localparam logic [OPW-1:0] ALU_SRL  = OPW'(6);
  localparam logic [OPW-1:0] ALU_SRA  = OPW'(7);
  localparam logic [OPW-1:0] ALU_SLT  = OPW'(8);
  localparam logic [OPW-1:0] ALU_SLTU = OPW'(9);
  localparam logic [OPW-1:0] ALU_EQ   = OPW'(10);
  localparam logic [OPW-1:0] ALU_NE   = OPW'(11);

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by the arbiter.
// Ports: aluOp (opcode), a/b (operands) -> out (result),
//        logicOutput (compare result for compare ops, zero flag otherwise).
// Unknown opcodes produce out = 0 (so logicOutput = 1).
module alu #(
  parameter int unsigned DW  = 32,
  parameter int unsigned OPW = 6
) (
  input  logic [OPW-1:0] aluOp,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  output logic [DW-1:0]  out,
  output logic           logicOutput
);
  import alu_pkg::*;

  localparam int unsigned SHW = $clog2(DW);

  logic cmp;
  logic is_cmp;

  // Opcode decode; compare ops return their result in bit 0 of out
  always_comb begin
    out    = '0;
    cmp    = 1'b0;
    is_cmp = 1'b0;
    case (aluOp)
      ALU_ADD:  out = a + b;
      ALU_SUB:  out = a - b;
      ALU_AND:  out = a & b;
      ALU_OR:   out = a | b;
      ALU_XOR:  out = a ^ b;
      ALU_SLL:  out = a << b[SHW-1:0];
      ALU_SRL:  out = a >> b[SHW-1:0];
      ALU_SRA:  out = $signed(a) >>> b[SHW-1:0];
      ALU_SLT:  begin is_cmp = 1'b1; cmp = ($signed(a) < $signed(b)); end
      ALU_SLTU: begin is_cmp = 1'b1; cmp = (a < b); end
      ALU_EQ:   begin is_cmp = 1'b1; cmp = (a == b); end
      ALU_NE:   begin is_cmp = 1'b1; cmp = (a != b); end
      default:  out = '0;
    endcase
    if (is_cmp) out = DW'(cmp);
    logicOutput = is_cmp ? cmp : (out == '0);
  end

endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant logic.
// Ports: eligible_i (per-port eligibility), last_i (last granted port)
//        -> grant_o (one-hot or zero), next_last_o (pointer after this cycle).
module rr_arb2 (
  input  logic                eligible_i0,
  input  logic                eligible_i1,
  input  alu_pkg::port_id_t   last_i,
  output logic [1:0]          grant_o,
  output alu_pkg::port_id_t   next_last_o
);

  // On a tie the port that did not win last time is granted
  always_comb begin
    grant_o     = 2'b00;
    next_last_o = last_i;
    case ({eligible_i1, eligible_i0})
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
    if (grant_o[1])      next_last_o = 1'b1;
    else if (grant_o[0]) next_last_o = 1'b0;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// Round-robin grant feeds a registered issue stage (S1) that drives the
// ALU; results land in a one-entry response buffer per requester.
// Ports: clk, reset_n (async active-low);
//        req_valid/req_ready + req_op*/req_a*/req_b* (request channels);
//        rsp_valid/rsp_ready + rsp_out*/rsp_flag* (response channels).
module alu_share_arbiter #(
  parameter int unsigned DW  = 32,
  parameter int unsigned OPW = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [OPW-1:0] req_op0,
  input  logic [OPW-1:0] req_op1,
  input  logic [DW-1:0]  req_a0,
  input  logic [DW-1:0]  req_b0,
  input  logic [DW-1:0]  req_a1,
  input  logic [DW-1:0]  req_b1,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [DW-1:0]  rsp_out0,
  output logic [DW-1:0]  rsp_out1,
  output logic           rsp_flag0,
  output logic           rsp_flag1
);
  import alu_pkg::*;

  issue_t        s1_q, s1_d;
  port_id_t      last_q, last_d;
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic [1:0]    rsp_valid_q;
  logic [DW-1:0] rsp_out0_q, rsp_out1_q;
  logic          rsp_flag0_q, rsp_flag1_q;
  logic [DW-1:0] alu_out;
  logic          alu_flag;
  logic [1:0]    rsp_load, rsp_clr;

  // At most one transaction in flight per port: not in S1, buffer free or freeing
  always_comb begin
    elig[0] = reset_n && req_valid[0] && !(s1_q.valid && (s1_q.id == 1'b0))
              && (!rsp_valid_q[0] || rsp_ready[0]);
    elig[1] = reset_n && req_valid[1] && !(s1_q.valid && (s1_q.id == 1'b1))
              && (!rsp_valid_q[1] || rsp_ready[1]);
  end

  rr_arb2 u_arb (
    .eligible_i0 (elig[0]),
    .eligible_i1 (elig[1]),
    .last_i      (last_q),
    .grant_o     (grant),
    .next_last_o (last_d)
  );

  assign req_ready = grant;

  // Issue stage next state: load winner, otherwise drop valid and hold data
  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = 1'b0;
    if (grant[0]) begin
      s1_d.valid = 1'b1;
      s1_d.id    = 1'b0;
      s1_d.op    = req_op0;
      s1_d.a     = req_a0;
      s1_d.b     = req_b0;
    end else if (grant[1]) begin
      s1_d.valid = 1'b1;
      s1_d.id    = 1'b1;
      s1_d.op    = req_op1;
      s1_d.a     = req_a1;
      s1_d.b     = req_b1;
    end
  end

  alu #(.DW(DW), .OPW(OPW)) u_alu (
    .aluOp       (s1_q.op),
    .a           (s1_q.a),
    .b           (s1_q.b),
    .out         (alu_out),
    .logicOutput (alu_flag)
  );

  always_comb begin
    rsp_load[0] = s1_q.valid && (s1_q.id == 1'b0);
    rsp_load[1] = s1_q.valid && (s1_q.id == 1'b1);
    rsp_clr     = rsp_valid_q & rsp_ready;
  end

  // Issue stage, round-robin pointer and response buffers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q        <= '0;
      last_q      <= 1'b1;
      rsp_valid_q <= 2'b00;
      rsp_out0_q  <= '0;
      rsp_out1_q  <= '0;
      rsp_flag0_q <= 1'b0;
      rsp_flag1_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      last_q <= last_d;
      for (int i = 0; i < 2; i++) begin
        if (rsp_load[i])     rsp_valid_q[i] <= 1'b1;
        else if (rsp_clr[i]) rsp_valid_q[i] <= 1'b0;
      end
      if (rsp_load[0]) begin
        rsp_out0_q  <= alu_out;
        rsp_flag0_q <= alu_flag;
      end
      if (rsp_load[1]) begin
        rsp_out1_q  <= alu_out;
        rsp_flag1_q <= alu_flag;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_out0  = rsp_out0_q;
  assign rsp_out1  = rsp_out1_q;
  assign rsp_flag0 = rsp_flag0_q;
  assign rsp_flag1 = rsp_flag1_q;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

- Shares one instance of the existing combinational `alu` between two requesters, e.g. the EX stage and the self-test/debug port.
- Each requester has its own valid/ready request channel and its own valid/ready response channel.
- Arbitration is round-robin. There is one registered issue stage in front of the ALU and a one-entry response buffer per requester.
- Sits between the pipeline control logic and the ALU datapath.

## Interface

Parameters:
- `DW`, 32: operand and result width; must match `alu`.
- `OPW`, 6: ALU opcode width; must match `alu` `aluOp`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: reset is asynchronous and active-low.
- `req_valid[1:0]`, input, 2: request i is presented.
- `req_ready[1:0]`, output, 2: request i is accepted this cycle; transfer when valid && ready.
- `req_op0` / `req_op1`, input, OPW: opcode for port 0 / port 1.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`, input, DW: operands.
- `rsp_valid[1:0]`, output, 2: response i is held.
- `rsp_ready[1:0]`, input, 2: consumer of response i accepts it.
- `rsp_out0` / `rsp_out1`, output, DW: ALU `out` captured for port i.
- `rsp_flag0` / `rsp_flag1`, output, 1: ALU `logicOutput` captured for port i.

## Operation

**Issue register S1** holds `{s1_valid, s1_id, op, a, b}`. The `alu` is driven only from S1.

**Eligibility.** Port i is eligible when all of the following hold:
- `req_valid[i]` is high;
- S1 does not hold id i;
- `rsp_valid[i]` is low, or `rsp_valid[i] && rsp_ready[i]` this cycle.

This means at most one transaction is outstanding per port.

**Round-robin grant.** Pointer `last` records the last granted port.
- One port eligible: grant it.
- Both eligible: grant `!last`.
- `last` updates only on a grant.
- `req_ready[i]` equals `grant[i]`, combinational from valid, S1 and the response state. It never depends on `req_op`, `req_a` or `req_b`.

**S1 update.**
- On a grant, S1 loads the winner's fields and sets `s1_valid` = 1.
- With no grant, `s1_valid` = 0 and the data fields hold their values.
- S1 never stalls: its target response buffer is guaranteed free by the eligibility rule.

**Response buffer i.**
- Loaded with `alu.out` and `alu.logicOutput` when `s1_valid && s1_id == i`.
- Cleared when `rsp_valid[i] && rsp_ready[i]`.
- A load and a clear in the same cycle cannot collide: a load happens only if the buffer was empty or freed one cycle earlier.

**Widths.** No arithmetic in this block. Operands pass unmodified at DW bits.

## Timing

- Reset values:
  - `req_ready` = 0 while in reset.
  - `rsp_valid` = 2'b00.
  - `rsp_out0`, `rsp_out1` = 0; `rsp_flag0`, `rsp_flag1` = 0.
  - `s1_valid` = 0.
  - `last` = 1, so port 0 wins the first tie.
- Latency: request accepted at edge N; S1 valid after N; `rsp_valid[i]` high after edge N+1. That is 2 cycles from acceptance to response.
- Throughput:
  - One grant per cycle in total.
  - A single port can issue at most every 2 cycles. Its next grant is possible in the cycle its response is consumed.
  - Two ports alternating can sustain 1 result per cycle.
- Response data holds stable while `rsp_valid && !rsp_ready`.
- `reset_n` low mid-operation: S1 and the response buffers are discarded immediately (asynchronously). No response is ever produced for a transaction accepted before reset.

## Structure

- Shared package `alu_pkg`:
  - `DW` and `OPW` constants;
  - port-id typedef (1 bit);
  - issue-record struct `{valid, id, op, a, b}`.
- Sub-module `rr_arb2`:
  - inputs: eligible[1:0], last;
  - outputs: grant[1:0] (one-hot or zero), next_last.
- `alu` is instantiated unchanged inside the block.

## Test plan

1. **Single request.** Port 0 only, `req_op0` = 6'd0, a = 32'h11ac5670, b = 32'ha1ac5670, `rsp_ready0` = 1.
   - `req_ready0` = 1 in cycle 0.
   - `rsp_valid0` = 1 in cycle 2.
   - `rsp_out0` / `rsp_flag0` equal a bench-side `alu` instance driven with the same inputs.
2. **Tie after reset.** Both ports valid, a = b = 32'ha1ac5670.
   - Port 0 is granted in cycle 0 and port 1 in cycle 1.
   - Responses arrive in cycles 2 and 3, each on its own port.
3. **Backpressure.** Port 1 with `rsp_ready1` = 0 and continuous `req_valid1`.
   - Exactly one grant is given.
   - `req_ready1` stays 0 and `rsp_out1` stays stable for 10 cycles.
   - Raise `rsp_ready1`: the response is consumed and the next grant occurs in the same cycle.
4. **Sustained alternation.** Both ports always ready and valid for 20 cycles.
   - Grants alternate 0,1,0,1,…
   - 20 responses total, 10 per port.
5. **Reset mid-operation.** Pull `reset_n` low one cycle after a grant.
   - All outputs drop to their reset values without waiting for a clock edge.
   - After release, no stale `rsp_valid` appears and the first tie goes to port 0.
6. **Opcode sweep.** Sweep `req_op0` from 0 to 63 with a = 32'h11ac5670 and b = 32'h11ac5670.
   - Every response matches the bench `alu` instance.
